sync_fifo_ext: RTL and testbench
================================

// Module: sync_fifo_ext
// PURPOSE
//  Single-clock FIFO, parametrised successor of the basic sync FIFO. Adds an occupancy count,
//  programmable almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) mode,
//  sticky overflow/underflow with clear, and simultaneous read/write at full. Drop-in buffer
//  between same-clock producer/consumer stages in the datapath.
// PARAMETERS
//  DATA_WIDTH  8       width of each stored word
//  DEPTH       32      number of entries; must be a power of 2, >= 4
//  ADDR_WIDTH  $clog2(DEPTH)  pointer width (derived, do not override)
//  AF_LEVEL    DEPTH-2 almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL    2       almost_empty asserts when count <= AE_LEVEL
//  FWFT        0       0 = standard (registered read, 1-cycle latency); 1 = fall-through
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  rst           in   1             synchronous, active-high reset
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write data
//  rd_en         in   1             read request / pop
//  rd_data       out  DATA_WIDTH    read data
//  rd_valid      out  1             rd_data holds a newly read word (standard) / head valid (FWFT)
//  count         out  ADDR_WIDTH+1  current occupancy 0..DEPTH
//  full, empty   out  1             count==DEPTH / count==0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  overflow      out  1             sticky: write attempted while full and not accepted
//  underflow     out  1             sticky: read attempted while empty
//  err_clr       in   1             clears overflow/underflow next edge
// BEHAVIOUR
//  - Reset (rst=1 at edge): pointers, count=0, rd_data=0, rd_valid=0, overflow=underflow=0;
//    empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0). Memory contents not reset.
//  - Pointers ADDR_WIDTH+1 bits; MSB is the wrap bit; full/empty from count, registered.
//  - wr_acc = wr_en & (!full | rd_acc); rd_acc = rd_en & !empty.
//    At full, simultaneous rd+wr: both accepted, count unchanged. At empty, simultaneous rd+wr:
//    read refused (underflow set), write accepted, count -> 1.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither. Never exceeds DEPTH.
//  - Standard mode: rd_data <= mem[rd_ptr] on rd_acc, rd_valid=1 for that following cycle only;
//    rd_data holds last value otherwise.
//  - FWFT mode: rd_data = mem[rd_ptr] whenever !empty, rd_valid = !empty; rd_acc pops, next
//    word visible the cycle after. Written word visible on rd_data the cycle after wr_acc.
//  - overflow set on wr_en & !wr_acc; underflow set on rd_en & empty. Sticky until err_clr or rst;
//    same-cycle set and err_clr: set wins.
//  - Pointer wrap: index DEPTH-1 -> 0 with wrap-bit toggle; no special casing of wrap cycle.
//  - Flags and count update on the same edge as the accepted transfer (no extra latency).
//  - rst mid-stream discards all data; outputs at reset values the cycle after the rst edge.
// STRUCTURE
//  - fifo_pkg: FIFO_MODE_STD/FIFO_MODE_FWFT constants, shared threshold/depth check functions.
//  - Sub-module fifo_mem: simple dual-port register array (1 write port, 1 async read port);
//    control, pointers, count, flags and the read-data register live in sync_fifo_ext.
//  - Elaboration-time error if DEPTH not power of 2 or AE_LEVEL >= AF_LEVEL.
// TESTING (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2, both FWFT values)
//  1 Reset: rst=1 2 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0.
//  2 Fill: write 0x10..0x17 -> count 1..8, almost_empty drops at count=3, almost_full at 6,
//    full at 8; 9th write 0xFF -> overflow=1, count=8, 0xFF never read back.
//  3 Drain: read 8 -> data 0x10..0x17 in order (standard: 1-cycle latency, FWFT: 0x10 on
//    rd_data before first rd_en); 9th read -> underflow=1; err_clr -> both flags 0.
//  4 Full + simultaneous rd/wr of 0xAA -> no overflow, count stays 8, 0xAA read 8th later.
//  5 Wrap: 20 interleaved wr/rd cycles of incrementing data -> pointers wrap twice, output
//    sequence exact, count never > 8, full/empty never false-asserted.
//  6 rst asserted with count=5 -> next cycle count=0, empty=1; subsequent write 0x55 reads 0x55.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for the FIFO family.
package fifo_pkg;

    // Read-side behaviour selector for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Smallest depth that still leaves room for distinct almost-empty/almost-full thresholds
    localparam int FIFO_MIN_DEPTH = 4;

    // Depth must be a power of two so the pointer wrap bit works without modulo logic
    function automatic bit depth_ok(input int depth);
        return (depth >= FIFO_MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

    // Thresholds must be ordered and reachable by the occupancy counter
    function automatic bit levels_ok(input int ae_level, input int af_level, input int depth);
        return (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

    // Only the two defined read modes are meaningful
    function automatic bit mode_ok(input int mode);
        return (mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the controller never exposes unwritten entries as valid.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address on an accepted write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost flags, optional
// first-word-fall-through read, and sticky overflow/underflow error flags.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    // Parameter sanity: stop elaboration rather than build a FIFO with broken flags
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ext: DEPTH (%0d) must be a power of 2 and >= %0d", DEPTH, FIFO_MIN_DEPTH);
    end
    if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
        $error("sync_fifo_ext: need 0 <= AE_LEVEL (%0d) < AF_LEVEL (%0d) <= DEPTH", AE_LEVEL, AF_LEVEL);
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr
        $error("sync_fifo_ext: ADDR_WIDTH is derived from DEPTH and must not be overridden");
    end
    if (!mode_ok(FWFT)) begin : g_bad_mode
        $error("sync_fifo_ext: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
    end

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit above the array index
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH:0]   ptr_span;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // A read pops only real data; a write at full is allowed when a pop frees the slot
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rd_data)
    );

    // Next occupancy: push-only grows, pop-only shrinks, both or neither leave it unchanged
    always_comb begin
        count_next = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and status flags all move on the edge of the accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
        end
    end

    // Sticky error flags; a fresh error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

    // The wrap-bit pointer distance must always agree with the occupancy register
    assign ptr_span = wr_ptr - rd_ptr;

    // Consistency check between the pointer pair and count outside of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ptr_span == count);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head of queue is presented combinationally whenever data is held
        assign rd_data  = empty ? '0 : mem_rd_data;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: capture the head on a pop, flag it valid for one cycle, hold otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_rd_data;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench: drives a standard-mode and an FWFT-mode FIFO with identical
// stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_ext;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          err_clr;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic [3:0]    s_count, f_count;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    // Reference model state
    logic [DW-1:0] modelQ[$];
    bit            mOvf;
    bit            mUnf;
    bit            mValid;
    logic [DW-1:0] mData;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
    ) dut_std (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (s_rd_data), .rd_valid (s_rd_valid), .count (s_count),
        .full (s_full), .empty (s_empty), .almost_full (s_af), .almost_empty (s_ae),
        .overflow (s_ovf), .underflow (s_unf), .err_clr (err_clr)
    );

    sync_fifo_ext #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
    ) dut_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (f_rd_data), .rd_valid (f_rd_valid), .count (f_count),
        .full (f_full), .empty (f_empty), .almost_full (f_af), .almost_empty (f_ae),
        .overflow (f_ovf), .underflow (f_unf), .err_clr (err_clr)
    );

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour at a clock edge, expressed as queue operations
    task automatic modelEdge(input bit r_st, input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit isEmpty, isFull, rdOk, wrOk;
        if (r_st) begin
            modelQ.delete();
            mOvf   = 0;
            mUnf   = 0;
            mValid = 0;
            mData  = '0;
        end else begin
            isEmpty = (modelQ.size() == 0);
            isFull  = (modelQ.size() == DEPTH);
            rdOk    = r && !isEmpty;
            wrOk    = w && (!isFull || rdOk);
            mValid  = rdOk;
            if (rdOk) mData = modelQ.pop_front();
            if (wrOk) modelQ.push_back(d);
            mOvf = (w && !wrOk) || (mOvf && !c);
            mUnf = (r && isEmpty) || (mUnf && !c);
        end
    endtask

    // Compare both DUTs against the model after the edge has settled
    task automatic checkAll();
        int n;
        n = modelQ.size();
        checkOutput("std.count",        32'(s_count),    32'(n));
        checkOutput("std.full",         32'(s_full),     32'(n == DEPTH));
        checkOutput("std.empty",        32'(s_empty),    32'(n == 0));
        checkOutput("std.almost_full",  32'(s_af),       32'(n >= AF));
        checkOutput("std.almost_empty", 32'(s_ae),       32'(n <= AE));
        checkOutput("std.overflow",     32'(s_ovf),      32'(mOvf));
        checkOutput("std.underflow",    32'(s_unf),      32'(mUnf));
        checkOutput("std.rd_valid",     32'(s_rd_valid), 32'(mValid));
        checkOutput("std.rd_data",      32'(s_rd_data),  32'(mData));
        checkOutput("fwft.count",        32'(f_count),    32'(n));
        checkOutput("fwft.full",         32'(f_full),     32'(n == DEPTH));
        checkOutput("fwft.empty",        32'(f_empty),    32'(n == 0));
        checkOutput("fwft.almost_full",  32'(f_af),       32'(n >= AF));
        checkOutput("fwft.almost_empty", 32'(f_ae),       32'(n <= AE));
        checkOutput("fwft.overflow",     32'(f_ovf),      32'(mOvf));
        checkOutput("fwft.underflow",    32'(f_unf),      32'(mUnf));
        checkOutput("fwft.rd_valid",     32'(f_rd_valid), 32'(n > 0));
        if (n > 0) begin
            checkOutput("fwft.rd_data", 32'(f_rd_data), 32'(modelQ[0]));
        end
    endtask

    // One clock of stimulus: drive at the falling edge, model the rising edge, check just after
    task automatic applyStimulus(input bit r_st, input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        @(negedge clk);
        rst     = r_st;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        modelEdge(r_st, w, d, r, c);
        #1;
        checkAll();
    endtask

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;

        $display("[TB] reset");
        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0);

        $display("[TB] fill to full plus one");
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 8'(8'h10 + i), 0, 0);
        applyStimulus(0, 1, 8'hFF, 0, 0);

        $display("[TB] drain past empty and clear errors");
        for (int i = 0; i <= DEPTH; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);

        $display("[TB] simultaneous read/write at full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0, 0);
        applyStimulus(0, 1, 8'hAA, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);

        $display("[TB] pointer wrap with interleaved traffic");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 8'(8'h40 + i), (i % 5) != 4, 0);
        for (int i = 0; i <= DEPTH; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 1, 8'h77, 1, 1);
        applyStimulus(0, 0, 8'h00, 1, 0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(8'h60 + i), 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h55, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 99) < 55,
                          8'($urandom),
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
